// File: rtl/cpu_top.sv
// Single-cycle 32-bit MIPS-subset core with its instruction ROM, register file and data RAM.
// Define CPU_EXT_OPS_EN to add bne, ori and lui; otherwise those opcodes decode as NOP.
module cpu_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] gpr [0:31];

  assign rd1 = (ra1 == '0) ? '0 : gpr[ra1];
  assign rd2 = (ra2 == '0) ? '0 : gpr[ra2];

  // An unknown rst_n counts as deasserted, so only a definite 0 blocks the write.
  always_ff @(posedge clk) begin
    if (we && (rst_n !== 1'b0) && (wa != '0))
      gpr[wa] <= wd;
  end
endmodule

module cpu_imem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  logic [31:0] mem [0:DEPTH-1];

  assign data = mem[addr];

  always_ff @(posedge clk) begin
    if (load_en)
      mem[load_addr] <= load_data;
  end
endmodule

module cpu_dmem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:DEPTH-1];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we && (rst_n !== 1'b0))
      mem[addr] <= wdata;
  end
endmodule

module cpu_top #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = '0
) (
  input logic clk,
  input logic rst_n
);
  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
    OP_ADDI  = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW  = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A
  } funct_e;

  logic [31:0] pc, pc_next, pc_plus4, inst;
  logic [31:0] rs_val, rt_val, imm_sext, eff_addr, br_target, jmp_target;
  logic [31:0] mem_rdata, reg_wd;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, reg_wa;
  logic [15:0] imm;
  logic        reg_we, mem_we;
  logic        unused_bits;

  assign op       = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign funct    = inst[5:0];
  assign imm      = inst[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};

  assign pc_plus4   = pc + 32'd4;
  assign br_target  = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jmp_target = {pc_plus4[31:28], inst[25:0], 2'b00};
  assign eff_addr   = rs_val + imm_sext;

  assign unused_bits = ^{inst[10:6], pc[1:0], pc[31:IAW+2], eff_addr[1:0], eff_addr[31:DAW+2]};

  cpu_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) INST_MEM (
    .clk(clk), .load_en(1'b0), .load_addr('0), .load_data('0),
    .addr(pc[IAW+1:2]), .data(inst)
  );

  cpu_regfile REG_HEAP (
    .clk(clk), .rst_n(rst_n), .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val),
    .we(reg_we), .wa(reg_wa), .wd(reg_wd)
  );

  cpu_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) DATA_MEM (
    .clk(clk), .rst_n(rst_n), .addr(eff_addr[DAW+1:2]), .we(mem_we),
    .wdata(rt_val), .rdata(mem_rdata)
  );

  always_comb begin
    reg_we  = 1'b0;
    reg_wa  = rt;
    reg_wd  = '0;
    mem_we  = 1'b0;
    pc_next = pc_plus4;
    case (op)
      OP_RTYPE: begin
        reg_we = 1'b1;
        reg_wa = rd;
        case (funct)
          F_ADD:   reg_wd = rs_val + rt_val;
          F_SUB:   reg_wd = rs_val - rt_val;
          F_AND:   reg_wd = rs_val & rt_val;
          F_OR:    reg_wd = rs_val | rt_val;
          F_SLT:   reg_wd = {31'b0, ($signed(rs_val) < $signed(rt_val))};
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_we = 1'b1;
        reg_wd = rs_val + imm_sext;
      end
      OP_LW: begin
        reg_we = 1'b1;
        reg_wd = mem_rdata;
      end
      OP_SW:  mem_we = 1'b1;
      OP_BEQ: if (rs_val == rt_val) pc_next = br_target;
      OP_J:   pc_next = jmp_target;
`ifdef CPU_EXT_OPS_EN
      OP_BNE: if (rs_val != rt_val) pc_next = br_target;
      OP_ORI: begin
        reg_we = 1'b1;
        reg_wd = rs_val | {16'b0, imm};
      end
      OP_LUI: begin
        reg_we = 1'b1;
        reg_wd = {imm, 16'b0};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end
endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: preloads a short program, runs it and checks registers, memory and PC.
module tb_cpu_top;
  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_errors;

  cpu_top #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [31:0] prog [0:20];
  logic [31:0] exp7;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;

    prog[0]  = rtype(5'd1, 5'd2, 5'd3, 6'h20);          // add  $3,$1,$2
    prog[1]  = rtype(5'd1, 5'd2, 5'd4, 6'h22);          // sub  $4,$1,$2
    prog[2]  = rtype(5'd2, 5'd1, 5'd5, 6'h2A);          // slt  $5,$2,$1
    prog[3]  = itype(6'h23, 5'd0, 5'd6, 16'h0004);      // lw   $6,4($0)
    prog[4]  = itype(6'h2B, 5'd0, 5'd6, 16'h0008);      // sw   $6,8($0)
    prog[5]  = itype(6'h04, 5'd1, 5'd1, 16'h0002);      // beq  $1,$1,+2
    prog[6]  = itype(6'h08, 5'd0, 5'd8, 16'h0001);      // addi $8 (skipped)
    prog[7]  = itype(6'h08, 5'd0, 5'd9, 16'h0001);      // addi $9 (skipped)
    prog[8]  = itype(6'h08, 5'd0, 5'd0, 16'h0007);      // addi $0,$0,7
    prog[9]  = itype(6'h08, 5'd0, 5'd10, 16'hFFFF);     // addi $10,$0,-1
    prog[10] = rtype(5'd10, 5'd1, 5'd11, 6'h2A);        // slt  $11,$10,$1
    prog[11] = rtype(5'd2, 5'd1, 5'd12, 6'h22);         // sub  $12,$2,$1
    prog[12] = itype(6'h0F, 5'd0, 5'd7, 16'h1234);      // lui  $7,0x1234
    prog[13] = itype(6'h0D, 5'd7, 5'd7, 16'h5678);      // ori  $7,$7,0x5678
    prog[14] = rtype(5'd1, 5'd2, 5'd13, 6'h24);         // and  $13,$1,$2
    prog[15] = rtype(5'd1, 5'd2, 5'd14, 6'h25);         // or   $14,$1,$2
    prog[16] = itype(6'h04, 5'd1, 5'd2, 16'h0001);      // beq  $1,$2,+1 (not taken)
    prog[17] = itype(6'h08, 5'd0, 5'd15, 16'h0011);     // addi $15,$0,0x11
    prog[18] = rtype(5'd1, 5'd2, 5'd16, 6'h3F);         // unknown funct -> NOP
    prog[19] = itype(6'h23, 5'd0, 5'd17, 16'h0400);     // lw   $17,1024($0) wraps to mem[0]
    prog[20] = {6'h02, 26'd20};                         // j    20

    for (int i = 0; i < 256; i++) begin
      dut.INST_MEM.mem[i] = 32'h0;
      dut.DATA_MEM.mem[i] = 32'h0;
    end
    for (int i = 0; i < 21; i++) dut.INST_MEM.mem[i] = prog[i];
    for (int i = 0; i < 32; i++) dut.REG_HEAP.gpr[i] = 32'h0;
    dut.REG_HEAP.gpr[1]  = 32'd5;
    dut.REG_HEAP.gpr[2]  = 32'd3;
    dut.REG_HEAP.gpr[7]  = 32'hDEADBEEF;
    dut.REG_HEAP.gpr[16] = 32'h0BADF00D;
    dut.DATA_MEM.mem[0]  = 32'h600DCAFE;
    dut.DATA_MEM.mem[1]  = 32'hA5A5A5A5;

`ifdef CPU_EXT_OPS_EN
    exp7 = 32'h12345678;
`else
    exp7 = 32'hDEADBEEF;
`endif

    // Reset held through the first edge: nothing executes yet.
    @(posedge clk);
    #1;
    check("reset_pc", dut.pc, 32'h0);
    check("reset_no_exec", dut.REG_HEAP.gpr[3], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_pc", dut.pc, 32'h0);
    @(posedge clk);
    #1;
    check("first_exec_pc", dut.pc, 32'h4);
    check("first_exec_add", dut.REG_HEAP.gpr[3], 32'd8);

    repeat (30) @(negedge clk);
    check("sub", dut.REG_HEAP.gpr[4], 32'd2);
    check("slt_pos", dut.REG_HEAP.gpr[5], 32'd1);
    check("lw", dut.REG_HEAP.gpr[6], 32'hA5A5A5A5);
    check("sw", dut.DATA_MEM.mem[2], 32'hA5A5A5A5);
    check("beq_skip1", dut.REG_HEAP.gpr[8], 32'h0);
    check("beq_skip2", dut.REG_HEAP.gpr[9], 32'h0);
    check("r0_zero", dut.REG_HEAP.gpr[0], 32'h0);
    check("addi_neg", dut.REG_HEAP.gpr[10], 32'hFFFFFFFF);
    check("slt_signed", dut.REG_HEAP.gpr[11], 32'd1);
    check("sub_wrap", dut.REG_HEAP.gpr[12], 32'hFFFFFFFE);
    check("ext_ops", dut.REG_HEAP.gpr[7], exp7);
    check("and", dut.REG_HEAP.gpr[13], 32'd1);
    check("or", dut.REG_HEAP.gpr[14], 32'd7);
    check("beq_not_taken", dut.REG_HEAP.gpr[15], 32'h11);
    check("unknown_nop", dut.REG_HEAP.gpr[16], 32'h0BADF00D);
    check("dmem_wrap", dut.REG_HEAP.gpr[17], 32'h600DCAFE);
    check("jump_loop_pc", dut.pc, 32'd80);
    @(negedge clk);
    check("jump_loop_hold", dut.pc, 32'd80);

    // Mid-program reset: PC drops at once and the write at the held edge is suppressed.
    dut.REG_HEAP.gpr[3] = 32'h0;
    rst_n = 1'b0;
    #1;
    check("async_reset_pc", dut.pc, 32'h0);
    @(posedge clk);
    #1;
    check("reset_write_blocked", dut.REG_HEAP.gpr[3], 32'h0);
    check("reset_hold_pc", dut.pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerun_add", dut.REG_HEAP.gpr[3], 32'd8);
    check("rerun_pc", dut.pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
